// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch stage of the 8-bit processor.
// Holds the program counter and a writable instruction memory, and presents
// one registered instruction per cycle. It accepts downstream redirects and
// freezes on halt.
// Optional feature: define BUSCA_CONTADOR_EN to add the saturating 16-bit
// fetch counter output contador_buscas.
module busca_instrucao #(
    parameter int         TAM_MEM    = 64,
    parameter logic [7:0] PC_INICIAL = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        parar,
    input  logic        segurar,
    input  logic        desvia,
    input  logic [7:0]  endereco_desvio,
    input  logic        escreve_instr,
    input  logic [7:0]  endereco_escrita,
    input  logic [7:0]  dado_escrita,
    output logic [7:0]  instrucao,
    output logic [7:0]  endereco_atual,
    output logic        instrucao_valida,
`ifdef BUSCA_CONTADOR_EN
    output logic        parado,
    output logic [15:0] contador_buscas
`else
    output logic        parado
`endif
);

    localparam int AW = (TAM_MEM > 1) ? $clog2(TAM_MEM) : 1;

    typedef enum logic [1:0] {INICIO, BUSCANDO, PARADO} estado_t;

    estado_t    r_estado;
    logic [7:0] r_mem [0:TAM_MEM-1];
    logic [7:0] w_prox;

    // Out-of-range fetches return the halt opcode, so a runaway PC stops itself.
    function automatic logic [7:0] ler_mem(input logic [7:0] a);
        if (int'(a) < TAM_MEM) begin
            return r_mem[a[AW-1:0]];
        end
        return 8'hF0;
    endfunction

    // Next PC: a redirect target, or the current PC plus one (wraps at 8 bits).
    always_comb begin
        w_prox = desvia ? endereco_desvio : (endereco_atual + 8'd1);
    end

    // Program-load port. It is active in every state, including reset, and
    // drops out-of-range addresses. The fetch in the same cycle sees old data.
    always_ff @(posedge clock) begin
        if (escreve_instr && (int'(endereco_escrita) < TAM_MEM)) begin
            r_mem[endereco_escrita[AW-1:0]] <= dado_escrita;
        end
    end

    // Fetch FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado         <= INICIO;
            endereco_atual   <= PC_INICIAL;
            instrucao        <= 8'h00;
            instrucao_valida <= 1'b0;
            parado           <= 1'b0;
        end else begin
            case (r_estado)
                INICIO: begin
                    instrucao        <= ler_mem(PC_INICIAL);
                    endereco_atual   <= PC_INICIAL;
                    instrucao_valida <= 1'b1;
                    r_estado         <= BUSCANDO;
                end
                BUSCANDO: begin
                    if (parar) begin
                        instrucao_valida <= 1'b0;
                        parado           <= 1'b1;
                        r_estado         <= PARADO;
                    end else if (!segurar) begin
                        endereco_atual <= w_prox;
                        instrucao      <= ler_mem(w_prox);
                    end
                end
                PARADO: begin
                    r_estado <= PARADO;
                end
                default: begin
                    r_estado <= INICIO;
                end
            endcase
        end
    end

`ifdef BUSCA_CONTADOR_EN
    logic [15:0] r_contador;

    // Counts advancing fetch cycles and saturates at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_contador <= 16'h0000;
        end else if ((r_estado == BUSCANDO) && !parar && !segurar &&
                     (r_contador != 16'hFFFF)) begin
            r_contador <= r_contador + 16'd1;
        end
    end

    assign contador_buscas = r_contador;
`endif

endmodule
